// File: rtl/xor2_bist_ctrl.sv
// Built-in self-test sequencer for a two-input XOR gate: sweeps all input vectors, checks a^b, reports results.
// Optional first-failure capture is enabled by defining XOR2_BIST_CAPTURE_EN.
module xor2_bist_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic             fail_valid
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 32'sd1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(PASSES - 32'sd1);
  localparam logic [SW-1:0]    SW_ONE      = SW'(32'd1);
  localparam logic [PW-1:0]    PW_ONE      = PW'(32'd1);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(32'd1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + ERR_ONE;
  endfunction

  function automatic logic xor_mismatch(input logic a, input logic b, input logic o);
    return o ^ (a ^ b);
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       vec_r, vec_s;
  logic [SW-1:0]    settle_r, settle_s;
  logic [PW-1:0]    sweep_r, sweep_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             start_accept_s;
  logic             sample_s;
  logic             mismatch_s;

  // Next-state and next-output logic for the sequencer
  always_comb begin
    state_s        = state_r;
    vec_s          = vec_r;
    settle_s       = settle_r;
    sweep_s        = sweep_r;
    busy_s         = busy_r;
    done_s         = 1'b0;
    pass_s         = pass_r;
    err_s          = err_r;
    start_accept_s = 1'b0;
    sample_s       = 1'b0;
    mismatch_s     = xor_mismatch(vec_r[0], vec_r[1], dut_out);
    case (state_r)
      ST_IDLE: begin
        start_accept_s = start;
        if (start_accept_s) begin
          state_s  = ST_RUN;
          vec_s    = 2'b00;
          settle_s = {SW{1'b0}};
          sweep_s  = {PW{1'b0}};
          busy_s   = 1'b1;
          pass_s   = 1'b0;
          err_s    = ERR_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        sample_s = (settle_r == SETTLE_LAST);
        if (sample_s) begin
          settle_s = {SW{1'b0}};
          // vec wraps 11->00, so the gate inputs are back at 0 when the run ends
          vec_s    = vec_r + 2'd1;
          if (mismatch_s) begin
            err_s = sat_inc(err_r);
          end else begin
            err_s = err_r;
          end
          if (vec_r == 2'd3) begin
            if (sweep_r == PASS_LAST) begin
              state_s = ST_DONE;
              sweep_s = {PW{1'b0}};
              busy_s  = 1'b0;
              done_s  = 1'b1;
              pass_s  = (err_s == ERR_ZERO);
            end else begin
              sweep_s = sweep_r + PW_ONE;
            end
          end else begin
            sweep_s = sweep_r;
          end
        end else begin
          settle_s = settle_r + SW_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s  = ST_IDLE;
        vec_s    = 2'b00;
        settle_s = {SW{1'b0}};
        sweep_s  = {PW{1'b0}};
        busy_s   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      vec_r    <= 2'b00;
      settle_r <= {SW{1'b0}};
      sweep_r  <= {PW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= ERR_ZERO;
    end else begin
      state_r  <= state_s;
      vec_r    <= vec_s;
      settle_r <= settle_s;
      sweep_r  <= sweep_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      pass_r   <= pass_s;
      err_r    <= err_s;
    end
  end

  assign dut_a   = vec_r[0];
  assign dut_b   = vec_r[1];
  assign busy    = busy_r;
  assign done    = done_r;
  assign pass    = pass_r;
  assign err_cnt = err_r;

`ifdef XOR2_BIST_CAPTURE_EN
  logic [1:0] fail_vec_r, fail_vec_s;
  logic       fail_valid_r, fail_valid_s;

  // First-failure capture: only the first mismatch of a run is kept
  always_comb begin
    fail_vec_s   = fail_vec_r;
    fail_valid_s = fail_valid_r;
    if (start_accept_s) begin
      fail_vec_s   = 2'b00;
      fail_valid_s = 1'b0;
    end else if (sample_s && mismatch_s && !fail_valid_r) begin
      fail_vec_s   = vec_r;
      fail_valid_s = 1'b1;
    end else begin
      fail_vec_s   = fail_vec_r;
      fail_valid_s = fail_valid_r;
    end
  end

  // Capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec_r   <= 2'b00;
      fail_valid_r <= 1'b0;
    end else begin
      fail_vec_r   <= fail_vec_s;
      fail_valid_r <= fail_valid_s;
    end
  end

  assign fail_vec   = fail_vec_r;
  assign fail_valid = fail_valid_r;
`else
  assign fail_vec   = 2'b00;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_xor2_bist_ctrl.sv
// Self-checking bench for xor2_bist_ctrl: three parameterisations driven by gate truth tables,
// checked against a sweep-level reference model.
module tb_xor2_bist_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic       start0, start1, start2;
  logic [3:0] tt0, tt1, tt2;
  logic       a0, b0, busy0, done0, pass0, fvv0, out0;
  logic       a1, b1, busy1, done1, pass1, fvv1, out1;
  logic       a2, b2, busy2, done2, pass2, fvv2, out2;
  logic [2:0] err0, err2;
  logic [1:0] err1;
  logic [1:0] fv0, fv1, fv2;

  // gate under test modelled as a truth table indexed by {b,a}
  assign out0 = tt0[{b0, a0}];
  assign out1 = tt1[{b1, a1}];
  assign out2 = tt2[{b2, a2}];

  xor2_bist_ctrl d0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(out0), .dut_a(a0), .dut_b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0), .fail_valid(fvv0)
  );
  xor2_bist_ctrl #(.SETTLE_CYCLES(4), .PASSES(1), .ERR_W(2)) d1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(out1), .dut_a(a1), .dut_b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1), .fail_valid(fvv1)
  );
  xor2_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(3)) d2 (
    .clk(clk), .rst(rst), .start(start2), .dut_out(out2), .dut_a(a2), .dut_b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2), .fail_valid(fvv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observations of the most recent run
  int         obs_busy, obs_done, obs_done_k, obs_trace_bad, obs_overlap, obs_clear_bad, obs_err;
  logic       obs_pass, obs_fvv;
  logic [1:0] obs_fv;

  // sampled outputs of the selected instance
  logic       oa, ob, obusy, odone, opass, ofvv;
  logic [1:0] ofv;
  int         oerr;

  task automatic sample(input int inst);
    case (inst)
      0: begin oa = a0; ob = b0; obusy = busy0; odone = done0; opass = pass0; oerr = int'(err0); ofv = fv0; ofvv = fvv0; end
      1: begin oa = a1; ob = b1; obusy = busy1; odone = done1; opass = pass1; oerr = int'(err1); ofv = fv1; ofvv = fvv1; end
      default: begin oa = a2; ob = b2; obusy = busy2; odone = done2; opass = pass2; oerr = int'(err2); ofv = fv2; ofvv = fvv2; end
    endcase
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic set_tt(input int inst, input logic [3:0] tt);
    case (inst)
      0: tt0 = tt;
      1: tt1 = tt;
      default: tt2 = tt;
    endcase
  endtask

  task automatic get_cfg(input int inst, output int s, output int p, output int w);
    case (inst)
      0: begin s = 4; p = 1; w = 3; end
      1: begin s = 4; p = 1; w = 2; end
      default: begin s = 1; p = 2; w = 3; end
    endcase
  endtask

  // reference: count mismatches over all sweeps, saturate, remember the first failing vector
  task automatic model(input logic [3:0] tt, input int p, input int w,
                       output int e_err, output logic e_pass, output logic [1:0] e_fv, output logic e_fvv);
    int cnt;
    int first;
    int maxv;
    cnt = 0;
    first = -1;
    for (int sw = 0; sw < p; sw++) begin
      for (int v = 0; v < 4; v++) begin
        if (int'(tt[v]) != ((v & 1) ^ (v >> 1))) begin
          cnt++;
          if (first < 0) first = v;
        end
      end
    end
    maxv = (1 << w) - 1;
    e_err = (cnt > maxv) ? maxv : cnt;
    e_pass = (cnt == 0);
`ifdef XOR2_BIST_CAPTURE_EN
    e_fv = (first < 0) ? 2'b00 : 2'(first);
    e_fvv = (cnt > 0);
`else
    e_fv = 2'b00;
    e_fvv = 1'b0;
`endif
  endtask

  // one start pulse (or held start), then observe a bounded window of cycles
  task automatic do_run(input int inst, input bit hold);
    int s, p, w, total;
    get_cfg(inst, s, p, w);
    total = 4 * s * p;
    obs_busy = 0; obs_done = 0; obs_done_k = -1; obs_trace_bad = 0; obs_overlap = 0; obs_clear_bad = 0;
    obs_err = -1; obs_pass = 1'b0; obs_fv = 2'b00; obs_fvv = 1'b0;
    @(negedge clk);
    set_start(inst, 1'b1);
    @(negedge clk);
    if (!hold) set_start(inst, 1'b0);
    for (int k = 0; k < total + 4; k++) begin
      sample(inst);
      if (k == 0 && (opass !== 1'b0 || oerr != 0 || ofvv !== 1'b0)) obs_clear_bad++;
      if (obusy === 1'b1) begin
        obs_busy++;
        if (k >= total || {ob, oa} !== 2'((k / s) % 4)) obs_trace_bad++;
      end else if ({ob, oa} !== 2'b00) begin
        obs_trace_bad++;
      end
      if (obusy === 1'b1 && odone === 1'b1) obs_overlap++;
      if (odone === 1'b1) begin
        obs_done++;
        obs_done_k = k;
        obs_pass = opass;
        obs_err = oerr;
        obs_fv = ofv;
        obs_fvv = ofvv;
      end
      if (hold && k == total - 1) set_start(inst, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_sweep(input string name, input int inst, input logic [3:0] tt, input bit hold);
    int s, p, w, e_err;
    logic e_pass, e_fvv;
    logic [1:0] e_fv;
    get_cfg(inst, s, p, w);
    set_tt(inst, tt);
    model(tt, p, w, e_err, e_pass, e_fv, e_fvv);
    do_run(inst, hold);
    checks++; if (obs_busy != 4 * s * p) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, obs_busy, 4 * s * p); end
    checks++; if (obs_done != 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, obs_done); end
    checks++; if (obs_done_k != 4 * s * p) begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, obs_done_k, 4 * s * p); end
    checks++; if (obs_trace_bad != 0) begin errors++; $display("FAIL %s vector_trace: got %0d bad cycles expected 0", name, obs_trace_bad); end
    checks++; if (obs_overlap != 0) begin errors++; $display("FAIL %s busy_done_overlap: got %0d expected 0", name, obs_overlap); end
    checks++; if (obs_clear_bad != 0) begin errors++; $display("FAIL %s clear_on_start: got %0d expected 0", name, obs_clear_bad); end
    checks++; if (obs_pass !== e_pass) begin errors++; $display("FAIL %s pass: got %b expected %b", name, obs_pass, e_pass); end
    checks++; if (obs_err != e_err) begin errors++; $display("FAIL %s err_cnt: got %0d expected %0d", name, obs_err, e_err); end
    checks++; if (obs_fv !== e_fv) begin errors++; $display("FAIL %s fail_vec: got %b expected %b", name, obs_fv, e_fv); end
    checks++; if (obs_fvv !== e_fvv) begin errors++; $display("FAIL %s fail_valid: got %b expected %b", name, obs_fvv, e_fvv); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tt0 = 4'b0110; tt1 = 4'b0110; tt2 = 4'b0110;
    repeat (3) @(negedge clk);
    checks++; if ({a0, b0, busy0, done0, pass0, err0, fv0, fvv0} !== 11'd0) begin errors++; $display("FAIL reset_d0: got %b expected 0", {a0, b0, busy0, done0, pass0, err0, fv0, fvv0}); end
    checks++; if ({a1, b1, busy1, done1, pass1, err1, fv1, fvv1} !== 10'd0) begin errors++; $display("FAIL reset_d1: got %b expected 0", {a1, b1, busy1, done1, pass1, err1, fv1, fvv1}); end
    checks++; if ({a2, b2, busy2, done2, pass2, err2, fv2, fvv2} !== 11'd0) begin errors++; $display("FAIL reset_d2: got %b expected 0", {a2, b2, busy2, done2, pass2, err2, fv2, fvv2}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_xor_default();
    test_sweep("xor_default", 0, 4'b0110, 1'b0);
    checks++; if (obs_busy != 16 || obs_err != 0 || obs_pass !== 1'b1) begin errors++; $display("FAIL xor_default_const: got busy=%0d err=%0d pass=%b expected 16/0/1", obs_busy, obs_err, obs_pass); end
  endtask

  task automatic test_stuck0();
    test_sweep("stuck0", 0, 4'b0000, 1'b0);
    checks++; if (obs_err != 2 || obs_pass !== 1'b0) begin errors++; $display("FAIL stuck0_const: got err=%0d pass=%b expected 2/0", obs_err, obs_pass); end
`ifdef XOR2_BIST_CAPTURE_EN
    checks++; if (obs_fv !== 2'b01 || obs_fvv !== 1'b1) begin errors++; $display("FAIL stuck0_capture: got vec=%b valid=%b expected 01/1", obs_fv, obs_fvv); end
`else
    checks++; if (obs_fv !== 2'b00 || obs_fvv !== 1'b0) begin errors++; $display("FAIL stuck0_nocapture: got vec=%b valid=%b expected 00/0", obs_fv, obs_fvv); end
`endif
  endtask

  task automatic test_xnor_saturate();
    test_sweep("xnor_sat", 1, 4'b1001, 1'b0);
    checks++; if (obs_err != 3 || obs_pass !== 1'b0) begin errors++; $display("FAIL xnor_sat_const: got err=%0d pass=%b expected 3/0", obs_err, obs_pass); end
  endtask

  task automatic test_stuck1_hold();
    test_sweep("stuck1_hold", 2, 4'b1111, 1'b1);
    checks++; if (obs_busy != 8 || obs_err != 4 || obs_done != 1) begin errors++; $display("FAIL stuck1_hold_const: got busy=%0d err=%0d done=%0d expected 8/4/1", obs_busy, obs_err, obs_done); end
  endtask

  task automatic test_reset_midrun();
    int k;
    int dones;
    tt0 = 4'b1111;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (k < 6) begin
      @(negedge clk);
      k++;
    end
    checks++; if (busy0 !== 1'b1 || err0 !== 3'd1) begin errors++; $display("FAIL midrun_pre: got busy=%b err=%0d expected 1/1", busy0, err0); end
    rst = 1'b1;
    #1;
    checks++; if ({a0, b0, busy0, done0, pass0, err0, fv0, fvv0} !== 11'd0) begin errors++; $display("FAIL midrun_reset: got %b expected 0", {a0, b0, busy0, done0, pass0, err0, fv0, fvv0}); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", dones); end
    test_sweep("after_reset", 0, 4'b0110, 1'b0);
  endtask

  task automatic test_random();
    int inst;
    logic [3:0] tt;
    bit hold;
    for (int i = 0; i < 10; i++) begin
      inst = int'($urandom_range(0, 2));
      tt = 4'($urandom_range(0, 15));
      hold = 1'($urandom_range(0, 1));
      test_sweep("random", inst, tt, hold);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_xor_default();
    test_stuck0();
    test_xnor_saturate();
    test_stuck1_hold();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
